// File: rtl/dsp_conv_loader.sv
// Stream-to-tile loader: turns valid/ready beats into image-URAM writes or double-buffered kernel-BRAM writes.
// Define DSP_CONV_LOADER_CHKSUM_EN to build the running XOR checksum; otherwise chksum is tied to zero.
module dsp_conv_loader #(
    parameter int unsigned KERN_SZ  = 3,
    parameter int unsigned IMG_W    = 4,
    parameter int unsigned IMG_D    = 6,
    parameter int unsigned A_W      = 14,
    parameter int unsigned M_W      = 18,
    parameter int unsigned URAM_D_W = 72,
    parameter int unsigned URAM_A_W = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_start,
    input  logic                cmd_kernel,
    input  logic [URAM_A_W-1:0] cmd_base,
    input  logic [URAM_D_W-1:0] s_data,
    input  logic                s_valid,
    input  logic                s_last,
    output logic                s_ready,
    output logic [URAM_A_W-1:0] uram1_wr_addr,
    output logic [URAM_D_W-1:0] uram1_wr_data,
    output logic                uram1_wr_en,
    output logic [A_W-1:0]      krnl_bram1_wraddr,
    output logic [M_W-1:0]      krnl_bram1_wrdata,
    output logic                krnl_bram1_wren,
    output logic [A_W-1:0]      krnl_bram2_wraddr,
    output logic [M_W-1:0]      krnl_bram2_wrdata,
    output logic                krnl_bram2_wren,
    output logic                ld_new_kernel,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [URAM_D_W-1:0] chksum
);

    localparam int unsigned KRN_N = KERN_SZ * KERN_SZ;
    localparam int unsigned IMG_N = IMG_W * IMG_W * IMG_D;
    localparam int unsigned MAX_N = (IMG_N > KRN_N) ? IMG_N : KRN_N;
    localparam int unsigned CNT_W = $clog2(MAX_N + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_IMG,
        S_LOAD_KRN,
        S_DRAIN,
        S_FIN
    } state_e;

    state_e              state_q, state_d;
    logic                is_krn_q, is_krn_d;
    logic [URAM_A_W-1:0] base_q, base_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                bank_q, bank_d;       // 0 = bank 1 active, 1 = bank 2 active
    logic                s_ready_q, s_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ld_new_kernel_q, ld_new_kernel_d;
    logic                uram_en_q, uram_en_d;
    logic [URAM_A_W-1:0] uram_addr_q, uram_addr_d;
    logic [URAM_D_W-1:0] uram_data_q, uram_data_d;
    logic                k1_en_q, k1_en_d;
    logic [A_W-1:0]      k1_addr_q, k1_addr_d;
    logic [M_W-1:0]      k1_data_q, k1_data_d;
    logic                k2_en_q, k2_en_d;
    logic [A_W-1:0]      k2_addr_q, k2_addr_d;
    logic [M_W-1:0]      k2_data_q, k2_data_d;
`ifdef DSP_CONV_LOADER_CHKSUM_EN
    logic [URAM_D_W-1:0] csum_q, csum_d;
    logic [URAM_D_W-1:0] chksum_q, chksum_d;
`endif

    logic             beat_acc;
    logic [CNT_W-1:0] last_idx;

    assign beat_acc = s_valid && s_ready_q;
    assign last_idx = is_krn_q ? CNT_W'(KRN_N - 1) : CNT_W'(IMG_N - 1);

    // Next-state, write-port and status computation
    always_comb begin
        state_d         = state_q;
        is_krn_d        = is_krn_q;
        base_d          = base_q;
        cnt_d           = cnt_q;
        err_d           = err_q;
        bank_d          = bank_q;
        s_ready_d       = 1'b0;
        busy_d          = 1'b0;
        done_d          = 1'b0;
        ld_new_kernel_d = 1'b0;
        uram_en_d       = 1'b0;
        uram_addr_d     = '0;
        uram_data_d     = '0;
        k1_en_d         = 1'b0;
        k1_addr_d       = '0;
        k1_data_d       = '0;
        k2_en_d         = 1'b0;
        k2_addr_d       = '0;
        k2_data_d       = '0;
`ifdef DSP_CONV_LOADER_CHKSUM_EN
        csum_d          = csum_q;
        chksum_d        = chksum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    is_krn_d = cmd_kernel;
                    base_d   = cmd_base;
                    cnt_d    = '0;
                    err_d    = 1'b0;
`ifdef DSP_CONV_LOADER_CHKSUM_EN
                    csum_d   = '0;
`endif
                    state_d  = cmd_kernel ? S_LOAD_KRN : S_LOAD_IMG;
                end
            end
            S_LOAD_IMG, S_LOAD_KRN: begin
                if (beat_acc) begin
                    if (state_q == S_LOAD_KRN) begin
                        if (!bank_q) begin
                            k1_en_d   = 1'b1;
                            k1_addr_d = A_W'(cnt_q);
                            k1_data_d = s_data[M_W-1:0];
                        end else begin
                            k2_en_d   = 1'b1;
                            k2_addr_d = A_W'(cnt_q);
                            k2_data_d = s_data[M_W-1:0];
                        end
                    end else begin
                        uram_en_d   = 1'b1;
                        uram_addr_d = base_q + URAM_A_W'(cnt_q);
                        uram_data_d = s_data;
                    end
`ifdef DSP_CONV_LOADER_CHKSUM_EN
                    csum_d = csum_q ^ s_data;
`endif
                    cnt_d = cnt_q + CNT_W'(1);
                    // Full-length beat decides between clean finish and overrun drain
                    if (cnt_q == last_idx) begin
                        if (s_last) begin
                            state_d = S_FIN;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
                        end
                    end else if (s_last) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end
            S_DRAIN: begin
                if (beat_acc) begin
`ifdef DSP_CONV_LOADER_CHKSUM_EN
                    csum_d = csum_q ^ s_data;
`endif
                    if (s_last) begin
                        state_d = S_FIN;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // FIN-cycle pulses are registered on entry so they coincide with the last write
        if (state_d == S_FIN) begin
            done_d = 1'b1;
            if (is_krn_q && !err_d) begin
                ld_new_kernel_d = 1'b1;
                bank_d          = ~bank_q;
            end
`ifdef DSP_CONV_LOADER_CHKSUM_EN
            chksum_d = csum_d;
`endif
        end

        s_ready_d = (state_d == S_LOAD_IMG) || (state_d == S_LOAD_KRN) || (state_d == S_DRAIN);
        busy_d    = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            is_krn_q        <= 1'b0;
            base_q          <= '0;
            cnt_q           <= '0;
            err_q           <= 1'b0;
            bank_q          <= 1'b0;
            s_ready_q       <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            ld_new_kernel_q <= 1'b0;
            uram_en_q       <= 1'b0;
            uram_addr_q     <= '0;
            uram_data_q     <= '0;
            k1_en_q         <= 1'b0;
            k1_addr_q       <= '0;
            k1_data_q       <= '0;
            k2_en_q         <= 1'b0;
            k2_addr_q       <= '0;
            k2_data_q       <= '0;
`ifdef DSP_CONV_LOADER_CHKSUM_EN
            csum_q          <= '0;
            chksum_q        <= '0;
`endif
        end else begin
            state_q         <= state_d;
            is_krn_q        <= is_krn_d;
            base_q          <= base_d;
            cnt_q           <= cnt_d;
            err_q           <= err_d;
            bank_q          <= bank_d;
            s_ready_q       <= s_ready_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            ld_new_kernel_q <= ld_new_kernel_d;
            uram_en_q       <= uram_en_d;
            uram_addr_q     <= uram_addr_d;
            uram_data_q     <= uram_data_d;
            k1_en_q         <= k1_en_d;
            k1_addr_q       <= k1_addr_d;
            k1_data_q       <= k1_data_d;
            k2_en_q         <= k2_en_d;
            k2_addr_q       <= k2_addr_d;
            k2_data_q       <= k2_data_d;
`ifdef DSP_CONV_LOADER_CHKSUM_EN
            csum_q          <= csum_d;
            chksum_q        <= chksum_d;
`endif
        end
    end

    assign s_ready           = s_ready_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
    assign ld_new_kernel     = ld_new_kernel_q;
    assign uram1_wr_en       = uram_en_q;
    assign uram1_wr_addr     = uram_addr_q;
    assign uram1_wr_data     = uram_data_q;
    assign krnl_bram1_wren   = k1_en_q;
    assign krnl_bram1_wraddr = k1_addr_q;
    assign krnl_bram1_wrdata = k1_data_q;
    assign krnl_bram2_wren   = k2_en_q;
    assign krnl_bram2_wraddr = k2_addr_q;
    assign krnl_bram2_wrdata = k2_data_q;
`ifdef DSP_CONV_LOADER_CHKSUM_EN
    assign chksum            = chksum_q;
`else
    assign chksum            = '0;
`endif

endmodule

// File: doc/dsp_conv_loader.md
# dsp_conv_loader

Upstream feeder for one `dsp_conv_top` tile. It converts a valid/ready beat stream into the tile's image-URAM write port (`uram1_wr_*`) and its double-buffered kernel BRAM write ports (`krnl_bram1_*`, `krnl_bram2_*`). Kernel loads alternate between the two kernel banks, and each completed kernel load pulses `ld_new_kernel`. One instance sits in front of each tile in `dsp_conv_chip`.

## Interface
Parameters:
- `KERN_SZ`, 3: kernel edge. A kernel load is `KERN_SZ*KERN_SZ` = 9 beats.
- `IMG_W`, 4: image edge.
- `IMG_D`, 6: image depth. An image load is `IMG_W*IMG_W*IMG_D` = 96 beats.
- `A_W`, 14: kernel BRAM address width.
- `M_W`, 18: kernel word width.
- `URAM_D_W`, 72: stream and URAM data width.
- `URAM_A_W`, 23: URAM address width.

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous, active-low.
- `cmd_start`, in, 1: start-load strobe, sampled only in IDLE.
- `cmd_kernel`, in, 1: 1 selects a kernel load, 0 an image load. Sampled with `cmd_start`.
- `cmd_base`, in, `URAM_A_W`: image base address. Sampled with `cmd_start`.
- `s_data`, in, `URAM_D_W`: stream data.
- `s_valid`, in, 1: stream data valid.
- `s_last`, in, 1: marks the final beat of a load.
- `s_ready`, out, 1: loader accepts a beat.
- `uram1_wr_addr`, out, `URAM_A_W`; `uram1_wr_data`, out, `URAM_D_W`; `uram1_wr_en`, out, 1: image URAM write port.
- `krnl_bram1_wraddr`, out, `A_W`; `krnl_bram1_wrdata`, out, `M_W`; `krnl_bram1_wren`, out, 1: kernel bank 1 write port.
- `krnl_bram2_wraddr`, out, `A_W`; `krnl_bram2_wrdata`, out, `M_W`; `krnl_bram2_wren`, out, 1: kernel bank 2 write port.
- `ld_new_kernel`, out, 1: one-cycle pulse, a kernel bank is complete.
- `busy`, out, 1: FSM is not in IDLE.
- `done`, out, 1: one-cycle pulse at end of any load.
- `err`, out, 1: sticky length error; cleared by the next accepted `cmd_start`.
- `chksum`, out, `URAM_D_W`: checksum of the last load (see Configuration).

## Operation
- **States:** IDLE, LOAD_IMG, LOAD_KRN, DRAIN, FIN.
- **IDLE:**
  - `cmd_start=1` latches `cmd_kernel` and `cmd_base`, clears the beat counter and `err`.
  - Next state is LOAD_KRN if `cmd_kernel=1`, else LOAD_IMG.
- **Beat accept:** a beat is accepted when `s_valid & s_ready`.
- **`s_ready`:** 1 exactly in LOAD_IMG, LOAD_KRN and DRAIN.
- **LOAD_IMG:** each accepted beat `n` (0-based) writes `uram1_wr_addr = cmd_base + n` and `uram1_wr_data = s_data`. The address wraps modulo 2^`URAM_A_W`.
- **LOAD_KRN:**
  - Each accepted beat `n` writes `s_data[M_W-1:0]` to address `n` of the active kernel bank.
  - The active bank is bank 1 after reset and toggles after each completed kernel load.
- **Length rules** (N = 96 for an image load, 9 for a kernel load):
  - Beat N-1 with `s_last=1`: normal completion, go to FIN.
  - Beat N-1 with `s_last=0`: set `err`, go to DRAIN.
  - `s_last=1` on beat n < N-1: that beat is written, `err` is set, go to FIN.
- **DRAIN:** accepts and discards beats with no writes until a beat with `s_last=1`, then goes to FIN.
- **FIN:**
  - Pulses `done` and returns to IDLE.
  - On a kernel load with `err=0`, also pulses `ld_new_kernel` and toggles the bank.
  - A kernel load with `err=1` does not toggle the bank and does not pulse `ld_new_kernel`.
- **`cmd_start` outside IDLE:** ignored.

## Timing
- **Reset:** all outputs are 0, the FSM is in IDLE and the active bank is bank 1.
- **Reset mid-load:** aborts immediately, with no `done` and no `ld_new_kernel`.
- **Start latency:** `cmd_start` in cycle T puts `s_ready=1` in T+1.
- **Write latency:** a beat accepted in cycle T produces its write strobe and registered address/data in T+1. Write enables are single-cycle per beat, and each write port drives its address/data to 0 when not enabled.
- **Final beat:** when the final beat is accepted in cycle T, `s_ready` is 0 in T+1 (FIN), the last write occurs in T+1, and `done`/`ld_new_kernel` pulse in T+1.
- **Earliest next start:** `busy` falls in T+2, so the next `cmd_start` is sampled at T+2 at the earliest.
- **Throughput:** full rate of one beat per cycle. Stalls on `s_valid=0` insert no writes.

## Configuration
- **`DSP_CONV_LOADER_CHKSUM_EN` defined:**
  - A running XOR of all accepted `s_data` beats in the load is computed; DRAIN beats are included.
  - The running XOR resets on `cmd_start`.
  - `chksum` updates in FIN and holds until the next FIN.
- **`DSP_CONV_LOADER_CHKSUM_EN` undefined:** `chksum` is tied to 0 and no checksum logic is built.

## Test plan
- **Image load:** `cmd_base=0x100`, 96 beats with data `i`, `s_last` on beat 95.
  - 96 URAM writes to 0x100..0x15F, each one cycle after acceptance.
  - `done` pulses once, `err=0`, `ld_new_kernel` never pulses.
- **Two kernel loads:** each 9 beats with `s_last` on beat 8.
  - First load writes bank 1, addresses 0..8, data = low 18 bits; second load writes bank 2.
  - Each load pulses `ld_new_kernel` and `done` together.
- **Short kernel:** `s_last` on beat 4.
  - Writes to addresses 0..4, `err=1`, `done` pulses, no `ld_new_kernel`.
  - The next kernel load still targets the same bank.
- **Long image:** 100 beats, `s_last` on beat 99.
  - 96 writes only, beats 96..99 discarded in DRAIN, `err=1`, `done` one cycle after beat 99.
- **Stalls and ignored start:** `s_valid` toggled 1/0 during an image load, and `cmd_start` pulsed mid-load.
  - Write addresses stay contiguous and the start pulse is ignored.
- **Reset mid-load plus checksum:** `rst` asserted after 40 image beats.
  - All outputs go to 0 and the next load targets bank 1.
  - With the macro defined, beats 0x1, 0x2, 0x4 ending with `s_last` give `chksum = 0x7`.
